// File: rtl/ctrl_in_cond_if.sv
// Signal bundle between the raw control lines and the conditioned levels/pulses.
// dbg_cnt exposes each channel's debounce counter: [0]=A, [1]=X, [2]=I.
interface ctrl_in_cond_if #(
    parameter int CNT_W = 3
);
    logic                  a_raw;
    logic                  x_raw;
    logic                  i_raw;
    logic                  A6;
    logic                  X3;
    logic                  I3;
    logic                  a_rise;
    logic                  x_rise;
    logic                  i_rise;
    logic                  a_fall;
    logic                  x_fall;
    logic                  i_fall;
    logic                  chg;
    logic [2:0][CNT_W-1:0] dbg_cnt;

    // master drives the raw lines; slave is the conditioning stage
    modport master (
        output a_raw, x_raw, i_raw,
        input  A6, X3, I3, a_rise, x_rise, i_rise, a_fall, x_fall, i_fall, chg, dbg_cnt
    );
    modport slave (
        input  a_raw, x_raw, i_raw,
        output A6, X3, I3, a_rise, x_rise, i_rise, a_fall, x_fall, i_fall, chg, dbg_cnt
    );
endinterface

// File: rtl/ctrl_in_cond.sv
// Input conditioning for the control FSM: two-flop sync, debounce, and
// registered rise/fall/change pulses for three independent channels.
module ctrl_in_cond #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic           clk,
    input  logic           rst_b,
    ctrl_in_cond_if.slave  bus
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    // channel index: 0 = A, 1 = X, 2 = I
    logic [2:0]            raw;
    logic [2:0]            s1;
    logic [2:0]            s2;
    logic [2:0]            lvl;
    logic [2:0]            rise;
    logic [2:0]            fall;
    logic [2:0]            upd;
    logic                  chg;
    logic [2:0][CNT_W-1:0] cnt;

    assign raw = {bus.i_raw, bus.x_raw, bus.a_raw};

    // a channel commits when its mismatch has persisted for the full window
    always_comb begin
        upd = '0;
        for (int c = 0; c < 3; c++) begin
            upd[c] = (s2[c] != lvl[c]) && (cnt[c] == LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            s1   <= '0;
            s2   <= '0;
            lvl  <= '0;
            rise <= '0;
            fall <= '0;
            chg  <= 1'b0;
            cnt  <= '0;
        end else begin
            s1  <= raw;
            s2  <= s1;
            chg <= |upd;
            for (int c = 0; c < 3; c++) begin
                rise[c] <= upd[c] & s2[c];
                fall[c] <= upd[c] & ~s2[c];
                if (s2[c] == lvl[c]) begin
                    cnt[c] <= '0;
                end else if (upd[c]) begin
                    lvl[c] <= s2[c];
                    cnt[c] <= '0;
                end else begin
                    cnt[c] <= cnt[c] + CNT_W'(1);
                end
            end
        end
    end

    assign bus.A6      = lvl[0];
    assign bus.X3      = lvl[1];
    assign bus.I3      = lvl[2];
    assign bus.a_rise  = rise[0];
    assign bus.x_rise  = rise[1];
    assign bus.i_rise  = rise[2];
    assign bus.a_fall  = fall[0];
    assign bus.x_fall  = fall[1];
    assign bus.i_fall  = fall[2];
    assign bus.chg     = chg;
    assign bus.dbg_cnt = cnt;
endmodule

// File: tb/tb_ctrl_in_cond.sv
// Directed bench for ctrl_in_cond: vector table for reset/steps, hand sequences
// for glitch, bounce, mid-debounce reset and the STABLE_CYCLES=1 variant.
module tb_ctrl_in_cond;
    logic clk = 1'b0;
    logic rst_b = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    ctrl_in_cond_if #(.CNT_W(3)) bus ();
    ctrl_in_cond_if #(.CNT_W(1)) bus_f ();

    ctrl_in_cond #(.STABLE_CYCLES(4), .CNT_W(3)) u_dut (
        .clk  (clk),
        .rst_b(rst_b),
        .bus  (bus.slave)
    );

    ctrl_in_cond #(.STABLE_CYCLES(1), .CNT_W(1)) u_fast (
        .clk  (clk),
        .rst_b(rst_b),
        .bus  (bus_f.slave)
    );

    typedef struct {
        logic       rst_b;
        logic       a;
        logic       x;
        logic       i;
        logic [2:0] lvl;   // {A6, X3, I3}
        logic [2:0] rise;  // {a, x, i}
        logic [2:0] fall;  // {a, x, i}
        logic       chg;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic a, input logic x, input logic i,
                       input logic [2:0] lvl, input logic [2:0] rise,
                       input logic [2:0] fall, input logic chg);
        vec_t v;
        v.rst_b = r; v.a = a; v.x = x; v.i = i;
        v.lvl = lvl; v.rise = rise; v.fall = fall; v.chg = chg;
        tbl.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int n_rise;
        int n_fall;
        int n_hi;
        logic seen_hi;

        bus.a_raw = 1'b1; bus.x_raw = 1'b1; bus.i_raw = 1'b1;
        bus_f.a_raw = 1'b0; bus_f.x_raw = 1'b0; bus_f.i_raw = 1'b0;

        // reset with raws high, then all levels rise together on the 6th edge
        repeat (2) add(0, 1, 1, 1, 3'b000, 3'b000, 3'b000, 0);
        repeat (5) add(1, 1, 1, 1, 3'b000, 3'b000, 3'b000, 0);
        add(1, 1, 1, 1, 3'b111, 3'b111, 3'b000, 1);
        add(1, 1, 1, 1, 3'b111, 3'b000, 3'b000, 0);
        // clean fall then clean rise on X only
        repeat (5) add(1, 1, 0, 1, 3'b111, 3'b000, 3'b000, 0);
        add(1, 1, 0, 1, 3'b101, 3'b000, 3'b010, 1);
        add(1, 1, 0, 1, 3'b101, 3'b000, 3'b000, 0);
        repeat (5) add(1, 1, 1, 1, 3'b101, 3'b000, 3'b000, 0);
        add(1, 1, 1, 1, 3'b111, 3'b010, 3'b000, 1);
        add(1, 1, 1, 1, 3'b111, 3'b000, 3'b000, 0);

        for (int k = 0; k < tbl.size(); k++) begin
            rst_b = tbl[k].rst_b;
            bus.a_raw = tbl[k].a; bus.x_raw = tbl[k].x; bus.i_raw = tbl[k].i;
            step();
            check($sformatf("vec%0d_lvl", k), {bus.A6, bus.X3, bus.I3}, tbl[k].lvl);
            check($sformatf("vec%0d_rise", k), {bus.a_rise, bus.x_rise, bus.i_rise}, tbl[k].rise);
            check($sformatf("vec%0d_fall", k), {bus.a_fall, bus.x_fall, bus.i_fall}, tbl[k].fall);
            check($sformatf("vec%0d_chg", k), bus.chg, tbl[k].chg);
        end

        // glitch of 3 cycles on I is rejected
        bus.i_raw = 1'b0;
        repeat (8) step();
        check("glitch_setup_I3", bus.I3, 0);
        n_rise = 0; seen_hi = 1'b0;
        bus.i_raw = 1'b1;
        for (int k = 0; k < 13; k++) begin
            if (k == 3) bus.i_raw = 1'b0;
            step();
            if (bus.i_rise) n_rise++;
            if (bus.I3) seen_hi = 1'b1;
        end
        check("glitch3_I3_never_high", seen_hi, 0);
        check("glitch3_no_rise", n_rise, 0);
        check("glitch3_cnt_cleared", bus.dbg_cnt[2], 0);

        // 4 cycles is just enough: one rise, then one debounced fall
        n_rise = 0; n_fall = 0; seen_hi = 1'b0;
        bus.i_raw = 1'b1;
        for (int k = 0; k < 24; k++) begin
            if (k == 4) bus.i_raw = 1'b0;
            step();
            if (bus.i_rise) n_rise++;
            if (bus.i_fall) n_fall++;
            if (bus.I3) seen_hi = 1'b1;
        end
        check("glitch4_I3_went_high", seen_hi, 1);
        check("glitch4_rise_count", n_rise, 1);
        check("glitch4_fall_count", n_fall, 1);
        check("glitch4_I3_final", bus.I3, 0);

        // bounce on A: 1,0,1,0 then held 1
        bus.a_raw = 1'b0;
        repeat (8) step();
        check("bounce_setup_A6", bus.A6, 0);
        n_rise = 0; first = 0;
        for (int k = 0; k < 4; k++) begin
            bus.a_raw = (k % 2 == 0) ? 1'b1 : 1'b0;
            step();
            if (bus.a_rise) n_rise++;
        end
        bus.a_raw = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (bus.a_rise) n_rise++;
            if (bus.A6 && first == 0) first = k;
        end
        check("bounce_rise_edge", first, 6);
        check("bounce_rise_count", n_rise, 1);

        // reset mid-debounce on X discards the partial count
        bus.x_raw = 1'b0;
        repeat (8) step();
        check("rstmid_setup_X3", bus.X3, 0);
        bus.x_raw = 1'b1;
        repeat (3) step();
        rst_b = 1'b0;
        step();
        check("rstmid_X3_in_reset", bus.X3, 0);
        check("rstmid_A6_in_reset", bus.A6, 0);
        check("rstmid_chg_in_reset", bus.chg, 0);
        check("rstmid_cnt_cleared", bus.dbg_cnt[1], 0);
        rst_b = 1'b1;
        first = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (bus.X3 && first == 0) first = k;
        end
        check("rstmid_X3_edge", first, 6);

        // STABLE_CYCLES=1: a one-cycle raw pulse passes through
        check("fast_setup_A6", bus_f.A6, 0);
        n_rise = 0; n_fall = 0; n_hi = 0;
        bus_f.a_raw = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            bus_f.a_raw = 1'b0;
            if (bus_f.A6) n_hi++;
            if (bus_f.a_rise) n_rise++;
            if (bus_f.a_fall) n_fall++;
            if (k == 3) begin
                check("fast_A6_at_3", bus_f.A6, 1);
                check("fast_rise_at_3", bus_f.a_rise, 1);
            end
            if (k == 4) begin
                check("fast_A6_at_4", bus_f.A6, 0);
                check("fast_fall_at_4", bus_f.a_fall, 1);
            end
        end
        check("fast_hi_cycles", n_hi, 1);
        check("fast_rise_count", n_rise, 1);
        check("fast_fall_count", n_fall, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ctrl_in_cond.md
Name: ctrl_in_cond

Overview:
- Input-conditioning stage directly upstream of the control FSM.
- Takes three raw, asynchronous control lines, synchronizes and debounces each one, and drives clean A6/X3/I3 levels to the FSM.
- Also produces single-cycle rise/fall pulses and a change strobe for downstream logic.
- All three channels are identical and independent.

Parameters:
STABLE_CYCLES, 4, consecutive post-sync cycles a new value must hold before the clean level updates (legal: >= 1)
CNT_W, 3, debounce counter width; must satisfy 2^CNT_W > STABLE_CYCLES-1

Ports:
clk  input  1  system clock, rising-edge active
rst_b  input  1  reset, synchronous, active-low
a_raw  input  1  raw asynchronous line for channel A
x_raw  input  1  raw asynchronous line for channel X
i_raw  input  1  raw asynchronous line for channel I
A6  output  1  debounced level of a_raw
X3  output  1  debounced level of x_raw
I3  output  1  debounced level of i_raw
a_rise  output  1  one-cycle pulse when A6 goes 0->1
x_rise  output  1  one-cycle pulse when X3 goes 0->1
i_rise  output  1  one-cycle pulse when I3 goes 0->1
a_fall  output  1  one-cycle pulse when A6 goes 1->0
x_fall  output  1  one-cycle pulse when X3 goes 1->0
i_fall  output  1  one-cycle pulse when I3 goes 1->0
chg  output  1  OR of all six rise/fall pulses

Behaviour:
- One clock (clk); reset is synchronous, active-low (rst_b). Reset acts only on a rising clk edge with rst_b=0.
- Reset values: sync flops s1/s2 = 0, counters = 0, A6 = X3 = I3 = 0, all rise/fall pulses = 0, chg = 0.
- Reset mid-debounce discards all progress, including any partial count.
- Per channel, synchronizer: s1 <= raw; s2 <= s1. Only s2 feeds the debouncer.
- Per channel, debouncer (lvl = the A6/X3/I3 output), evaluated on each rising edge:
  - s2 == lvl: cnt <= 0; lvl holds.
  - s2 != lvl and cnt < STABLE_CYCLES-1: cnt <= cnt+1; lvl holds.
  - s2 != lvl and cnt == STABLE_CYCLES-1: lvl <= s2; cnt <= 0.
- Latency:
  - Raw value first sampled at edge E0 and then held steady.
  - lvl updates at edge E0+STABLE_CYCLES+1, i.e. the (STABLE_CYCLES+2)th edge counting E0.
  - Default (4): output changes 6 edges after first sampling.
- Glitch rejection:
  - A post-sync mismatch lasting fewer than STABLE_CYCLES consecutive cycles never changes lvl.
  - The counter clears the first cycle s2 matches lvl again; there is no partial-credit accumulation.
- Pulses:
  - Registered; asserted on the same edge lvl updates, high for exactly one cycle.
  - rise when lvl 0->1; fall when lvl 1->0.
  - Never both rise and fall on the same channel in the same cycle.
- chg is registered with the pulses (same cycle), high when any channel updates. Simultaneous updates on several channels give one chg cycle, with each channel's own pulse high.
- STABLE_CYCLES=1: lvl <= s2 whenever they differ, so lvl trails s2 by one cycle. A single-cycle s2 pulse is passed through.
- No combinational path from raw inputs to any output; all outputs are flop outputs.

Test Plan:
- Reset: hold rst_b=0 for 2 edges with all raw=1 -> A6/X3/I3=0, all pulses 0, chg=0 during reset. After release, all three levels rise 6 edges later (default), with a_rise=x_rise=i_rise=chg=1 for exactly one cycle.
- Clean step on x_raw 0->1 at edge E0, then held -> X3=1 from edge E0+5; x_rise high for the cycle after E0+5 only; A6/I3 unchanged, a_rise/i_rise=0.
- Glitch: i_raw high for 3 cycles, then low, with STABLE_CYCLES=4 -> I3 stays 0, i_rise never asserts, counter returns to 0. Repeat with 4 cycles -> I3 goes 1, then back to 0 after the fall is debounced; i_fall pulses once.
- Bounce: a_raw toggles 1,0,1,0,1 at one-cycle spacing, then held 1 -> A6 rises exactly once, 6 edges after the final 1 is sampled; exactly one a_rise pulse.
- Reset mid-debounce: start x_raw 0->1, assert rst_b=0 for one edge 3 cycles later, keep x_raw=1 -> X3=0 immediately after reset. Full latency restarts from the first post-reset sampling edge: X3=1 six edges after reset release.
- Parameter override STABLE_CYCLES=1, CNT_W=1: a 1-cycle raw pulse on a_raw -> A6 high for exactly 1 cycle, 3 edges after sampling; a_rise and a_fall each pulse once on consecutive cycles.
